// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: bundle of the two requester ports and the SPRAM-side bus.
//   Port A / port B : req, wr, addr, wdata, ben -> arbiter; gnt, rvalid <- arbiter
//   rdata           : shared read data, qualified by a_rvalid / b_rvalid
//   mem_*           : registered SPRAM controls out, mem_rdata back in
//   modport slave   : arbiter view
//   modport master  : requester + SPRAM view (drives requests and mem_rdata)
interface spram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              a_req;
    logic              a_wr;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [3:0]        a_ben;
    logic              a_gnt;
    logic              a_rvalid;

    logic              b_req;
    logic              b_wr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [3:0]        b_ben;
    logic              b_gnt;
    logic              b_rvalid;

    logic [DATA_W-1:0] rdata;

    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_wr, a_addr, a_wdata, a_ben,
        input  b_req, b_wr, b_addr, b_wdata, b_ben,
        input  mem_rdata,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output a_req, a_wr, a_addr, a_wdata, a_ben,
        output b_req, b_wr, b_addr, b_wdata, b_ben,
        output mem_rdata,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port SPRAM between requester A (capture)
// and requester B (playback).
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : spram_arbiter_if.slave (both request ports + SPRAM bus)
// Grants are combinational from req and the round-robin pointer. The granted
// access is registered onto the SPRAM bus one cycle later; a {valid, port} tag
// follows it so read data comes back to the right port two cycles after grant.
module spram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int PRIO_A = 0
) (
    input  logic            clk,
    input  logic            reset,
    spram_arbiter_if.slave  bus
);

    logic              last_a;     // 1 = A was the most recent grant
    logic              gnt_a;
    logic              gnt_b;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_ben;

    logic [3:0]        we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        tag1;       // {read valid, port (1 = B)} at the SPRAM stage
    logic [1:0]        tag2;       // same tag, aligned with mem_rdata

    // A wins if alone, under fixed priority, or when B was granted last.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (bus.a_req && (!bus.b_req || PRIO_A != 0 || !last_a))
                gnt_a = 1'b1;
            else if (bus.b_req)
                gnt_b = 1'b1;
        end
    end

    always_comb begin
        sel_wr    = gnt_b ? bus.b_wr    : bus.a_wr;
        sel_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
        sel_ben   = gnt_b ? bus.b_ben   : bus.a_ben;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_a  <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            tag1    <= 2'b00;
            tag2    <= 2'b00;
        end else begin
            tag2 <= tag1;
            if (gnt_a || gnt_b) begin
                last_a  <= gnt_a;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                // ben = 0 naturally yields no write enable.
                we_q    <= sel_wr ? sel_ben : 4'b0000;
                tag1    <= {~sel_wr, gnt_b};
            end else begin
                // Idle: address/data hold to avoid needless SPRAM bus toggling.
                we_q <= 4'b0000;
                tag1 <= 2'b00;
            end
        end
    end

    assign bus.a_gnt     = gnt_a;
    assign bus.b_gnt     = gnt_b;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.a_rvalid  = tag2[1] & ~tag2[0];
    assign bus.b_rvalid  = tag2[1] &  tag2[0];

    // The SPRAM output is already a register stage (valid the cycle after the
    // address), so it is forwarded during the rvalid cycle rather than
    // registered again; this keeps the grant-to-rvalid latency at two cycles.
    assign bus.rdata     = tag2[1] ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;
    localparam int AW = 14;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [3:0]    a_ben = '0, b_ben = '0;

    spram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i0 ();
    spram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i1 ();

    assign i0.a_req = a_req;  assign i0.a_wr = a_wr;  assign i0.a_addr = a_addr;
    assign i0.a_wdata = a_wdata;  assign i0.a_ben = a_ben;
    assign i0.b_req = b_req;  assign i0.b_wr = b_wr;  assign i0.b_addr = b_addr;
    assign i0.b_wdata = b_wdata;  assign i0.b_ben = b_ben;
    assign i1.a_req = a_req;  assign i1.a_wr = a_wr;  assign i1.a_addr = a_addr;
    assign i1.a_wdata = a_wdata;  assign i1.a_ben = a_ben;
    assign i1.b_req = b_req;  assign i1.b_wr = b_wr;  assign i1.b_addr = b_addr;
    assign i1.b_wdata = b_wdata;  assign i1.b_ben = b_ben;

    spram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_A(0)) u0 (
        .clk(clk), .reset(reset), .bus(i0.slave));
    spram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_A(1)) u1 (
        .clk(clk), .reset(reset), .bus(i1.slave));

    // SPRAM models: synchronous read, nibble-masked write
    logic [DW-1:0] m0 [0:(1<<AW)-1];
    logic [DW-1:0] m1 [0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i0.mem_we[k]) m0[i0.mem_addr][4*k +: 4] <= i0.mem_wdata[4*k +: 4];
            if (i1.mem_we[k]) m1[i1.mem_addr][4*k +: 4] <= i1.mem_wdata[4*k +: 4];
        end
        i0.mem_rdata <= m0[i0.mem_addr];
        i1.mem_rdata <= m1[i1.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;   // 1 = B
        logic [15:0] data;
        int          cyc;
    } ev_t;

    ev_t gq0[$], gq1[$], rq0[$], rq1[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pg(input int d, input logic p, input int c);
        ev_t e;
        e.port = p; e.data = '0; e.cyc = c;
        if (d == 0) gq0.push_back(e); else gq1.push_back(e);
    endtask

    task automatic pr(input int d, input logic p, input logic [15:0] v, input int c);
        ev_t e;
        e.port = p; e.data = v; e.cyc = c;
        if (d == 0) rq0.push_back(e); else rq1.push_back(e);
    endtask

    task automatic mon(input int d, input logic ag, input logic bg,
                       input logic ar, input logic br, input logic [15:0] rd);
        ev_t e;
        int  n;
        if (ag && bg) chk($sformatf("d%0d dual grant", d), 1, 0);
        if (ag || bg) begin
            n = (d == 0) ? gq0.size() : gq1.size();
            if (n == 0) chk($sformatf("d%0d unexpected grant", d), 1, 0);
            else begin
                if (d == 0) e = gq0.pop_front(); else e = gq1.pop_front();
                chk($sformatf("d%0d gnt port", d), int'(bg), int'(e.port));
                chk($sformatf("d%0d gnt cycle", d), cyc, e.cyc);
            end
        end
        if (ar && br) chk($sformatf("d%0d dual rvalid", d), 1, 0);
        if (ar || br) begin
            n = (d == 0) ? rq0.size() : rq1.size();
            if (n == 0) chk($sformatf("d%0d unexpected rvalid", d), 1, 0);
            else begin
                if (d == 0) e = rq0.pop_front(); else e = rq1.pop_front();
                chk($sformatf("d%0d rvalid port", d), int'(br), int'(e.port));
                chk($sformatf("d%0d rdata", d), int'(rd), int'(e.data));
                chk($sformatf("d%0d rvalid cycle", d), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, i0.a_gnt, i0.b_gnt, i0.a_rvalid, i0.b_rvalid, i0.rdata);
        mon(1, i1.a_gnt, i1.b_gnt, i1.a_rvalid, i1.b_rvalid, i1.rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string nm, input logic [3:0] we,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        chk({nm, " d0 we"},    int'(i0.mem_we),    int'(we));
        chk({nm, " d0 addr"},  int'(i0.mem_addr),  int'(ad));
        chk({nm, " d0 wdata"}, int'(i0.mem_wdata), int'(wd));
        chk({nm, " d1 we"},    int'(i1.mem_we),    int'(we));
        chk({nm, " d1 addr"},  int'(i1.mem_addr),  int'(ad));
        chk({nm, " d1 wdata"}, int'(i1.mem_wdata), int'(wd));
    endtask

    task automatic rst_check(input string nm);
        chk({nm, " d0 flags"}, int'({i0.a_gnt, i0.b_gnt, i0.a_rvalid, i0.b_rvalid}), 0);
        chk({nm, " d0 rdata"}, int'(i0.rdata), 0);
        chk({nm, " d1 flags"}, int'({i1.a_gnt, i1.b_gnt, i1.a_rvalid, i1.b_rvalid}), 0);
        chk({nm, " d1 rdata"}, int'(i1.rdata), 0);
        chk_mem(nm, 4'h0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        reset = 1'b1;
        step(); step();
        rst_check("reset");
        reset = 1'b0;
        step();

        // A full write, B idle
        c = cyc;
        a_req = 1; a_wr = 1; a_addr = 14'h0005; a_wdata = 16'h1234; a_ben = 4'hF;
        pg(0, 0, c); pg(1, 0, c);
        step();
        a_req = 0;
        chk_mem("wr full", 4'hF, 14'h0005, 16'h1234);

        // B reads the just-written address the very next cycle
        c = cyc;
        b_req = 1; b_wr = 0; b_addr = 14'h0005;
        pg(0, 1, c); pg(1, 1, c);
        pr(0, 1, 16'h1234, c + 2); pr(1, 1, 16'h1234, c + 2);
        step();

        // B writes 0x5678 to addr 6
        c = cyc;
        b_wr = 1; b_addr = 14'h0006; b_wdata = 16'h5678; b_ben = 4'hF;
        pg(0, 1, c); pg(1, 1, c);
        step();
        b_req = 0;
        step(); step(); step();

        // Contention: both hold reads for 6 cycles
        c = cyc;
        a_req = 1; a_wr = 0; a_addr = 14'h0005;
        b_req = 1; b_wr = 0; b_addr = 14'h0006;
        for (int i = 0; i < 6; i++) begin
            pg(0, i[0], c + i);
            pr(0, i[0], i[0] ? 16'h5678 : 16'h1234, c + i + 2);
            pg(1, 1'b0, c + i);
            pr(1, 1'b0, 16'h1234, c + i + 2);
        end
        repeat (6) step();
        a_req = 0; b_req = 0;
        step(); step(); step(); step();

        // Partial write then read back
        c = cyc;
        a_req = 1; a_wr = 1; a_addr = 14'h0005; a_wdata = 16'hABCD; a_ben = 4'b0011;
        pg(0, 0, c); pg(1, 0, c);
        step();
        chk_mem("wr partial", 4'b0011, 14'h0005, 16'hABCD);
        c = cyc;
        a_wr = 0;
        pg(0, 0, c); pg(1, 0, c);
        pr(0, 0, 16'h12CD, c + 2); pr(1, 0, 16'h12CD, c + 2);
        step();

        // ben = 0 write is granted but writes nothing
        c = cyc;
        a_wr = 1; a_wdata = 16'hFFFF; a_ben = 4'b0000;
        pg(0, 0, c); pg(1, 0, c);
        step();
        chk_mem("wr ben0", 4'b0000, 14'h0005, 16'hFFFF);
        c = cyc;
        a_wr = 0;
        pg(0, 0, c); pg(1, 0, c);
        pr(0, 0, 16'h12CD, c + 2); pr(1, 0, 16'h12CD, c + 2);
        step();
        a_req = 0;
        step(); step(); step();

        // Reset one cycle after a B read grant: no rvalid may follow
        c = cyc;
        b_req = 1; b_wr = 0; b_addr = 14'h0006;
        pg(0, 1, c); pg(1, 1, c);
        step();
        b_req = 0;
        reset = 1'b1;
        step();
        rst_check("mid reset");
        reset = 1'b0;
        step();

        // After reset the pointer favours A
        c = cyc;
        a_req = 1; a_wr = 0; a_addr = 14'h0005;
        b_req = 1; b_wr = 0; b_addr = 14'h0006;
        pg(0, 0, c); pg(1, 0, c);
        pr(0, 0, 16'h12CD, c + 2); pr(1, 0, 16'h12CD, c + 2);
        step();
        a_req = 0; b_req = 0;
        repeat (5) step();

        chk("d0 pending grants", gq0.size(), 0);
        chk("d1 pending grants", gq1.size(), 0);
        chk("d0 pending reads",  rq0.size(), 0);
        chk("d1 pending reads",  rq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares the single 16K x 16 SPRAM between two requesters: port A (write-heavy capture side) and port B (read-heavy output side).
- Uses valid/grant request handshakes and round-robin (or fixed-priority) arbitration.
- Registers all SPRAM-side signals and returns read data with a fixed latency, tagged to the requesting port.
- Sits between the capture/playback logic and the spram instance in top.

Parameters:
- ADDR_W, 14, SPRAM word address width
- DATA_W, 16, data width
- PRIO_A, 0, 0 = round-robin between A and B; 1 = fixed priority, A always wins contention

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- a_req  input  1  port A request; held with its payload until a_gnt
- a_wr  input  1  port A access type: 1 = write, 0 = read
- a_addr  input  ADDR_W  port A word address
- a_wdata  input  DATA_W  port A write data
- a_ben  input  4  port A nibble write enables (bit i covers wdata[4i+3:4i])
- a_gnt  output  1  port A request accepted this cycle (combinational)
- a_rvalid  output  1  port A read data valid
- b_req, b_wr, b_addr, b_wdata, b_ben, b_gnt, b_rvalid  same as port A, for port B
- rdata  output  DATA_W  read data, shared by both ports, qualified by a_rvalid/b_rvalid
- mem_we  output  4  to SPRAM write enable (nibble mask)
- mem_addr  output  ADDR_W  to SPRAM address
- mem_wdata  output  DATA_W  to SPRAM data in
- mem_rdata  input  DATA_W  from SPRAM data out; valid the cycle after the address is presented

Behaviour:
- Reset values: a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. Priority pointer resets to favour A.
- Grant rules:
  - At most one grant per cycle; one access per cycle; full throughput (no bubbles).
  - x_gnt is combinational from x_req and the pointer. A requester sees grant in cycle N and may change its payload in N+1.
  - Only one requester: it is granted immediately.
  - Both request, PRIO_A = 0: grant the port not granted most recently. Pointer updates only on a grant.
  - Both request, PRIO_A = 1: grant A. B waits until A drops req.
- Stage 1 (registered, cycle N+1):
  - mem_addr and mem_wdata take the granted payload.
  - mem_we = ben if wr = 1 and ben != 0, else 4'b0000.
  - Idle cycle: mem_we = 0; mem_addr and mem_wdata hold their last value.
- Tag pipeline: a 2-bit {valid, port} tag follows the access. Reads only set valid; writes never produce rvalid.
- Stage 2 (cycle N+2): for a read, rdata <= mem_rdata and the tagged port's rvalid pulses for 1 cycle.
- Read latency: gnt in cycle N produces rvalid in cycle N+2, fixed. Back-to-back reads give back-to-back rvalid in grant order.
- Hazards:
  - A read granted in the cycle after a write to the same address returns the new data, since SPRAM writes complete before the next access.
  - Write with ben = 0 is accepted (gnt asserted) but issues no write.
- Request deasserted before grant: the request is withdrawn, with no side effect.
- Reset mid-operation: in-flight tags are cleared; no rvalid is emitted for any access granted before reset; mem_we is 0 from the cycle after reset is sampled.
- Address width: addresses are used unmodified; no wrap logic (ADDR_W matches the SPRAM).

Test Plan:
- A writes 0x1234 to addr 0x0005, ben = 4'hF, B idle -> a_gnt same cycle; mem_we = 4'hF, mem_addr = 0x0005, mem_wdata = 0x1234 next cycle; no rvalid.
- Then B reads addr 0x0005 -> b_gnt in cycle N, b_rvalid high exactly in N+2 with rdata = 0x1234; a_rvalid stays 0.
- A and B both hold read requests for 6 cycles, PRIO_A = 0 -> grants alternate A, B, A, B, A, B; rvalids alternate with a 2-cycle lag.
- Same stimulus with PRIO_A = 1 -> a_gnt every cycle, b_gnt never asserted while a_req is high.
- Partial write: A writes 0xABCD with ben = 4'b0011 over stored 0x1234, then reads -> rdata = 0x12CD.
- Reset asserted one cycle after a B read grant -> b_rvalid never asserts; all outputs read 0 the cycle after reset is sampled.
